// File: rtl/host_mailbox.sv
// host_mailbox: tohost/fromhost responder on the CPU data bus.
// TOHOST stores are decoded (pass / fail / proxy) one cycle after the store
// lands; proxy requests are handed to an external host over req/ack and the
// host's reply is returned through FROMHOST.
module host_mailbox #(
    parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000,
    parameter logic [31:0] FROMHOST_ADDR = 32'h0000_1040
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_we,
    input  logic [31:0] mem_wdata,
    input  logic        mem_re,
    output logic        mem_sel,
    output logic [31:0] mem_rdata,
    output logic        host_req,
    output logic [31:0] host_arg,
    input  logic        host_ack,
    input  logic [31:0] host_resp,
    output logic        test_done,
    output logic        test_pass,
    output logic [30:0] fail_code,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PROXY = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] tohost_q;
    logic [31:0] fromhost_q;
    logic        event_r;
    logic        hit_to_s;
    logic        hit_from_s;
    logic        tohost_wr_s;
    logic        fromhost_wr_s;
    logic        ack_take_s;
    logic        unused_s;

    // Merge the enabled byte lanes of new_v into old_v.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Word-address decode; byte offset bits do not take part.
    assign hit_to_s      = (mem_addr[31:2] == TOHOST_ADDR[31:2]);
    assign hit_from_s    = (mem_addr[31:2] == FROMHOST_ADDR[31:2]);
    assign mem_sel       = hit_to_s | hit_from_s;
    assign tohost_wr_s   = hit_to_s & (mem_we != 4'b0000);
    assign fromhost_wr_s = hit_from_s & (mem_we != 4'b0000);
    assign unused_s      = ^mem_addr[1:0];

    // Next-state decode: TOHOST events only matter in RUN; ack only in PROXY.
    always_comb begin
        state_nxt_s = state_r;
        ack_take_s  = 1'b0;
        case (state_r)
            S_RUN: begin
                if (event_r) begin
                    if (tohost_q == 32'd1) begin
                        state_nxt_s = S_PASS;
                    end else if (tohost_q[0]) begin
                        state_nxt_s = S_FAIL;
                    end else if (tohost_q != 32'd0) begin
                        state_nxt_s = S_PROXY;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_PROXY: begin
                if (host_ack) begin
                    state_nxt_s = S_RUN;
                    ack_take_s  = 1'b1;
                end else begin
                    state_nxt_s = S_PROXY;
                end
            end
            S_PASS:  state_nxt_s = S_PASS;
            S_FAIL:  state_nxt_s = S_FAIL;
            default: state_nxt_s = S_RUN;
        endcase
    end

    // State register and the one-cycle TOHOST write event.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= S_RUN;
            event_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            event_r <= tohost_wr_s;
        end
    end

    // Mailbox registers: the host ack clears TOHOST and overrides FROMHOST stores.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tohost_q   <= 32'd0;
            fromhost_q <= 32'd0;
        end else begin
            if (ack_take_s) begin
                tohost_q <= 32'd0;
            end else if (tohost_wr_s) begin
                tohost_q <= merge_bytes(tohost_q, mem_wdata, mem_we);
            end else begin
                tohost_q <= tohost_q;
            end
            if (ack_take_s) begin
                fromhost_q <= host_resp;
            end else if (fromhost_wr_s) begin
                fromhost_q <= merge_bytes(fromhost_q, mem_wdata, mem_we);
            end else begin
                fromhost_q <= fromhost_q;
            end
        end
    end

    // Load data path with one cycle of latency, like the data BRAM.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mem_rdata <= 32'd0;
        end else if (mem_re && hit_to_s) begin
            mem_rdata <= tohost_q;
        end else if (mem_re && hit_from_s) begin
            mem_rdata <= fromhost_q;
        end else begin
            mem_rdata <= 32'd0;
        end
    end

    // Host-facing and status outputs, registered from the next state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            host_req  <= 1'b0;
            host_arg  <= 32'd0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            fail_code <= 31'd0;
        end else begin
            host_req  <= (state_nxt_s == S_PROXY);
            test_done <= (state_nxt_s == S_PASS) || (state_nxt_s == S_FAIL);
            test_pass <= (state_nxt_s == S_PASS);
            if ((state_r == S_RUN) && (state_nxt_s == S_PROXY)) begin
                host_arg <= tohost_q;
            end else begin
                host_arg <= host_arg;
            end
            if ((state_r == S_RUN) && (state_nxt_s == S_FAIL)) begin
                fail_code <= tohost_q[31:1];
            end else begin
                fail_code <= fail_code;
            end
        end
    end

    // Saturating run-time counter, frozen once a terminal state is reached.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cycle_count <= 32'd0;
        end else if (((state_r == S_RUN) || (state_r == S_PROXY)) &&
                     (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end else begin
            cycle_count <= cycle_count;
        end
    end

endmodule

// File: tb/tb_host_mailbox.sv
// Bench for host_mailbox: directed scenarios followed by random traffic,
// every cycle compared against a behavioural mailbox model.
module tb_host_mailbox;

    localparam logic [31:0] TOHOST   = 32'h0000_1000;
    localparam logic [31:0] FROMHOST = 32'h0000_1040;
    localparam int M_RUN   = 0;
    localparam int M_PROXY = 1;
    localparam int M_PASS  = 2;
    localparam int M_FAIL  = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_sel;
    logic [31:0] mem_rdata;
    logic        host_req;
    logic [31:0] host_arg;
    logic        host_ack;
    logic [31:0] host_resp;
    logic        test_done;
    logic        test_pass;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_to, m_from, m_rd, m_arg, m_cnt;
    logic [30:0] m_code;
    int          m_mode;
    logic        m_ev;

    logic [31:0] tmp;

    host_mailbox dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_sel     (mem_sel),
        .mem_rdata   (mem_rdata),
        .host_req    (host_req),
        .host_arg    (host_arg),
        .host_ack    (host_ack),
        .host_resp   (host_resp),
        .test_done   (test_done),
        .test_pass   (test_pass),
        .fail_code   (fail_code),
        .cycle_count (cycle_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the model, advance, then compare every output.
    task automatic tick();
        logic [31:0] n_to, n_from, n_rd, n_arg, n_cnt;
        logic [30:0] n_code;
        int          n_mode;
        logic        n_ev, hit_to, hit_from;
        #1;
        hit_to   = (mem_addr[31:2] == TOHOST[31:2]);
        hit_from = (mem_addr[31:2] == FROMHOST[31:2]);
        chk("mem_sel", {31'd0, mem_sel}, {31'd0, hit_to | hit_from});
        if (sys_rst) begin
            n_to = 32'd0; n_from = 32'd0; n_rd = 32'd0; n_arg = 32'd0;
            n_code = 31'd0; n_cnt = 32'd0; n_mode = M_RUN; n_ev = 1'b0;
        end else begin
            n_rd = 32'd0;
            if (mem_re && hit_to) n_rd = m_to;
            else if (mem_re && hit_from) n_rd = m_from;
            n_to = m_to;
            n_from = m_from;
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b] && hit_to) n_to[8*b +: 8] = mem_wdata[8*b +: 8];
                if (mem_we[b] && hit_from) n_from[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            n_ev = hit_to && (mem_we != 4'd0);
            n_mode = m_mode; n_arg = m_arg; n_code = m_code;
            if (m_mode == M_RUN && m_ev) begin
                if (m_to == 32'd1) n_mode = M_PASS;
                else if (m_to[0]) begin n_mode = M_FAIL; n_code = m_to[31:1]; end
                else if (m_to != 32'd0) begin n_mode = M_PROXY; n_arg = m_to; end
            end else if (m_mode == M_PROXY && host_ack) begin
                n_from = host_resp;
                n_to = 32'd0;
                n_mode = M_RUN;
            end
            n_cnt = (m_mode <= M_PROXY && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
        end
        @(posedge sys_clk);
        #1;
        m_to = n_to; m_from = n_from; m_rd = n_rd; m_arg = n_arg;
        m_code = n_code; m_cnt = n_cnt; m_mode = n_mode; m_ev = n_ev;
        chk("mem_rdata", mem_rdata, m_rd);
        chk("host_req", {31'd0, host_req}, {31'd0, m_mode == M_PROXY});
        chk("host_arg", host_arg, m_arg);
        chk("test_done", {31'd0, test_done}, {31'd0, m_mode >= M_PASS});
        chk("test_pass", {31'd0, test_pass}, {31'd0, m_mode == M_PASS});
        chk("fail_code", {1'b0, fail_code}, {1'b0, m_code});
        chk("cycle_count", cycle_count, m_cnt);
    endtask

    task automatic idle();
        sys_rst = 1'b0; mem_we = 4'd0; mem_re = 1'b0; host_ack = 1'b0;
        mem_addr = 32'h0000_0000; mem_wdata = 32'd0; host_resp = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        mem_addr = addr; mem_wdata = data; mem_we = we;
        tick();
        idle();
    endtask

    task automatic load(input logic [31:0] addr);
        mem_addr = addr; mem_re = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        // Reset state.
        do_reset();
        chk("rst_done", {31'd0, test_done}, 32'd0);
        chk("rst_count", cycle_count, 32'd0);

        // Pass written on the 10th cycle after reset.
        for (int i = 0; i < 9; i++) tick();
        store(TOHOST, 32'd1, 4'hF);
        tick();
        chk("tp1_done", {31'd0, test_done}, 32'd1);
        chk("tp1_pass", {31'd0, test_pass}, 32'd1);
        chk("tp1_count", cycle_count, 32'd11);
        tick();
        chk("tp1_frozen", cycle_count, 32'd11);

        // Fail with code 3; later pass write is ignored.
        do_reset();
        store(TOHOST, 32'h0000_0007, 4'hF);
        tick();
        chk("tp2_done", {31'd0, test_done}, 32'd1);
        chk("tp2_code", {1'b0, fail_code}, 32'd3);
        store(TOHOST, 32'd1, 4'hF);
        tick();
        chk("tp2_pass", {31'd0, test_pass}, 32'd0);
        chk("tp2_code2", {1'b0, fail_code}, 32'd3);

        // Proxy request, delayed ack, read-back of both registers.
        do_reset();
        store(TOHOST, 32'h8000_0100, 4'hF);
        tick();
        chk("tp3_req", {31'd0, host_req}, 32'd1);
        chk("tp3_arg", host_arg, 32'h8000_0100);
        for (int i = 0; i < 5; i++) tick();
        chk("tp3_hold", {31'd0, host_req}, 32'd1);
        host_ack = 1'b1; host_resp = 32'h55; mem_addr = FROMHOST; mem_re = 1'b1;
        tick();
        idle();
        chk("tp3_oldread", mem_rdata, 32'd0);
        chk("tp3_reqdrop", {31'd0, host_req}, 32'd0);
        load(FROMHOST);
        chk("tp3_from", mem_rdata, 32'h55);
        load(TOHOST);
        chk("tp3_to", mem_rdata, 32'd0);

        // Byte stores.
        do_reset();
        store(TOHOST, 32'h0000_0001, 4'b0001);
        tick();
        chk("tp4_pass", {31'd0, test_pass}, 32'd1);
        store(TOHOST, 32'h00AB_0000, 4'b0100);
        load(TOHOST);
        chk("tp4_merge", mem_rdata, 32'h00AB_0001);

        // Reset during PROXY together with an ack.
        do_reset();
        store(TOHOST, 32'h0000_0002, 4'hF);
        tick();
        chk("tp5_req", {31'd0, host_req}, 32'd1);
        sys_rst = 1'b1; host_ack = 1'b1; host_resp = 32'h77;
        tick();
        idle();
        chk("tp5_req0", {31'd0, host_req}, 32'd0);
        chk("tp5_arg0", host_arg, 32'd0);
        chk("tp5_cnt0", cycle_count, 32'd0);
        load(FROMHOST);
        chk("tp5_from0", mem_rdata, 32'd0);

        // Unmapped load.
        mem_addr = 32'h0000_2000; mem_re = 1'b1;
        #1;
        chk("tp6_sel", {31'd0, mem_sel}, 32'd0);
        tick();
        idle();
        chk("tp6_rdata", mem_rdata, 32'd0);

        // Random traffic against the model.
        for (int it = 0; it < 2000; it++) begin
            idle();
            tmp = $urandom;
            case ($urandom_range(0, 4))
                0, 1:    mem_addr = {TOHOST[31:2], tmp[1:0]};
                2:       mem_addr = {FROMHOST[31:2], tmp[1:0]};
                3:       mem_addr = 32'h0000_2000;
                default: mem_addr = tmp;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                mem_we = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15));
            end
            case ($urandom_range(0, 5))
                0:       mem_wdata = 32'd1;
                1:       mem_wdata = $urandom | 32'd1;
                2:       mem_wdata = 32'd0;
                default: mem_wdata = $urandom & 32'hFFFF_FFFE;
            endcase
            mem_re    = ($urandom_range(0, 1) == 1);
            host_ack  = ($urandom_range(0, 3) == 0);
            host_resp = $urandom;
            sys_rst   = (m_mode >= M_PASS) ? ($urandom_range(0, 7) == 0)
                                           : ($urandom_range(0, 199) == 0);
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
